shift_reg_chain: RTL and testbench

//  - Parametrised cascade of STAGES shift registers, each WIDTH bits; one serial chain, all stages visible in parallel.
//  - Adds bidirectional shift, parallel load, serial out, and a frame counter that flags every full chain of shifts.
//  - Drives lab display/LED banks and feeds serial-to-parallel converters; generalises the fixed two-stage 4-bit SIPO.

---
 rtl/shift_reg_chain.sv | 101 ++++++++++
 tb/tb_shift_reg_chain.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_chain.sv
// shift_reg_chain: STAGES cascaded WIDTH-bit shift registers forming one serial chain of
// N = WIDTH*STAGES bits, with every stage visible in parallel.
//
// Optional feature: define ROTATE_EN to add the rotate port (circular shift).
//
// Ports:
//   clk        rising-edge clock
//   clear      asynchronous reset, active-high
//   shift_ctrl shift enable (1 = shift this edge)
//   dir        0 = shift toward MSB, 1 = shift toward LSB
//   s_in       serial data entering the chain
//   load       parallel load strobe (wins over shift_ctrl)
//   p_in       parallel load data
//   p_out      chain contents; stage k = p_out[k*WIDTH +: WIDTH]
//   s_out      bit that leaves on the next shift (combinational)
//   shift_cnt  shifts since last load/clear, modulo N
//   frame_done one-cycle pulse after the N-th shift of a frame
//   rotate     (ROTATE_EN only) recirculate the outgoing bit instead of s_in
module shift_reg_chain #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned STAGES = 2,
  localparam int unsigned N     = WIDTH * STAGES,
  localparam int unsigned CW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          shift_ctrl,
  input  logic          dir,
  input  logic          s_in,
  input  logic          load,
  input  logic [N-1:0]  p_in,
  output logic [N-1:0]  p_out,
  output logic          s_out,
  output logic [CW-1:0] shift_cnt,
`ifdef ROTATE_EN
  input  logic          rotate,
`endif
  output logic          frame_done
);

  logic [N-1:0]  chain_q, chain_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          frame_done_q, frame_done_d;

  logic          d_bit;
  logic [N-1:0]  shift_up, shift_dn;
  logic          cnt_wrap;

  assign s_out = dir ? chain_q[0] : chain_q[N-1];

`ifdef ROTATE_EN
  // Rotation feeds back the pre-shift outgoing bit.
  assign d_bit = rotate ? s_out : s_in;
`else
  assign d_bit = s_in;
`endif

  // A single-bit chain has no bits to keep; the new bit replaces it.
  generate
    if (N == 1) begin : g_single
      assign shift_up = d_bit;
      assign shift_dn = d_bit;
    end else begin : g_multi
      assign shift_up = {chain_q[N-2:0], d_bit};
      assign shift_dn = {d_bit, chain_q[N-1:1]};
    end
  endgenerate

  assign cnt_wrap = (cnt_q == CW'(N - 1));

  always_comb begin
    chain_d      = chain_q;
    cnt_d        = cnt_q;
    frame_done_d = 1'b0;
    if (load) begin
      chain_d = p_in;
      cnt_d   = '0;
    end else if (shift_ctrl) begin
      chain_d      = dir ? shift_dn : shift_up;
      cnt_d        = cnt_wrap ? '0 : cnt_q + CW'(1);
      frame_done_d = cnt_wrap;
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      chain_q      <= '0;
      cnt_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      chain_q      <= chain_d;
      cnt_q        <= cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign p_out      = chain_q;
  assign shift_cnt  = cnt_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_shift_reg_chain.sv
// Directed testbench for shift_reg_chain with WIDTH=4, STAGES=2 (N=8).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_shift_reg_chain;

  logic       clk;
  logic       clear;
  logic       shift_ctrl;
  logic       dir;
  logic       s_in;
  logic       load;
  logic [7:0] p_in;
  logic [7:0] p_out;
  logic       s_out;
  logic [2:0] shift_cnt;
  logic       frame_done;
`ifdef ROTATE_EN
  logic       rotate;
`endif

  int checks;
  int errors;

  shift_reg_chain #(
    .WIDTH  (4),
    .STAGES (2)
  ) dut (
    .clk        (clk),
    .clear      (clear),
    .shift_ctrl (shift_ctrl),
    .dir        (dir),
    .s_in       (s_in),
    .load       (load),
    .p_in       (p_in),
    .p_out      (p_out),
    .s_out      (s_out),
    .shift_cnt  (shift_cnt),
`ifdef ROTATE_EN
    .rotate     (rotate),
`endif
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear = 1'b0;
    load  = 1'b1;
    p_in  = 8'h5A;
    tick();
    load = 1'b0;
    checks++;
    if (p_out !== 8'h5A) begin
      errors++;
      $display("FAIL reset_preload p_out got %h want %h", p_out, 8'h5A);
    end
    // Assert clear between edges; it must take effect without a clock edge.
    #2;
    clear = 1'b1;
    #1;
    checks++;
    if (p_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_p_out got %h want %h", p_out, 8'h00);
    end
    checks++;
    if (shift_cnt !== 3'd0) begin
      errors++;
      $display("FAIL reset_cnt got %0d want 0", shift_cnt);
    end
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_frame_done got %b want 0", frame_done);
    end
    tick();
    clear = 1'b0;
    tick();
    checks++;
    if (p_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_release p_out got %h want %h", p_out, 8'h00);
    end
  endtask

  task automatic test_fill();
    logic [7:0] exp_tab [8];
    exp_tab = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
    dir        = 1'b0;
    s_in       = 1'b1;
    shift_ctrl = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (p_out !== exp_tab[i]) begin
        errors++;
        $display("FAIL fill_p_out[%0d] got %h want %h", i, p_out, exp_tab[i]);
      end
      checks++;
      if (shift_cnt !== 3'((i + 1) % 8)) begin
        errors++;
        $display("FAIL fill_cnt[%0d] got %0d want %0d", i, shift_cnt, (i + 1) % 8);
      end
      checks++;
      if (frame_done !== (i == 7)) begin
        errors++;
        $display("FAIL fill_frame_done[%0d] got %b want %b", i, frame_done, (i == 7));
      end
    end
    shift_ctrl = 1'b0;
    tick();
    checks++;
    if (frame_done !== 1'b0 || p_out !== 8'hFF) begin
      errors++;
      $display("FAIL fill_hold got fd=%b p_out=%h want fd=0 p_out=ff", frame_done, p_out);
    end
  endtask

  task automatic test_drain();
    logic [7:0] exp_bits;
    exp_bits = 8'b1010_0101;  // s_out sequence, first sample in bit 7
    load = 1'b1;
    p_in = 8'hA5;
    tick();
    load = 1'b0;
    checks++;
    if (p_out !== 8'hA5 || shift_cnt !== 3'd0) begin
      errors++;
      $display("FAIL drain_load got p_out=%h cnt=%0d want a5 0", p_out, shift_cnt);
    end
    dir        = 1'b1;
    s_in       = 1'b0;
    shift_ctrl = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (s_out !== exp_bits[7-i]) begin
        errors++;
        $display("FAIL drain_s_out[%0d] got %b want %b", i, s_out, exp_bits[7-i]);
      end
      tick();
    end
    shift_ctrl = 1'b0;
    checks++;
    if (p_out !== 8'h00) begin
      errors++;
      $display("FAIL drain_final got %h want 00", p_out);
    end
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL drain_frame_done got %b want 1", frame_done);
    end
  endtask

  task automatic test_priority_hold();
    dir        = 1'b0;
    s_in       = 1'b1;
    shift_ctrl = 1'b1;
    tick();  // one shift so the counter is non-zero before the load
    load = 1'b1;
    p_in = 8'h3C;
    tick();
    load       = 1'b0;
    shift_ctrl = 1'b0;
    checks++;
    if (p_out !== 8'h3C) begin
      errors++;
      $display("FAIL prio_p_out got %h want 3c", p_out);
    end
    checks++;
    if (shift_cnt !== 3'd0) begin
      errors++;
      $display("FAIL prio_cnt got %0d want 0", shift_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (p_out !== 8'h3C || frame_done !== 1'b0) begin
        errors++;
        $display("FAIL hold[%0d] got p_out=%h fd=%b want 3c 0", i, p_out, frame_done);
      end
    end
  endtask

  task automatic test_mid_frame_clear();
    int pulses;
    pulses     = 0;
    dir        = 1'b0;
    s_in       = 1'b0;
    shift_ctrl = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (frame_done === 1'b1) pulses++;
    end
    shift_ctrl = 1'b0;
    clear      = 1'b1;
    #2;
    clear = 1'b0;
    checks++;
    if (shift_cnt !== 3'd0 || p_out !== 8'h00) begin
      errors++;
      $display("FAIL mid_clear got cnt=%0d p_out=%h want 0 00", shift_cnt, p_out);
    end
    shift_ctrl = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (frame_done === 1'b1) pulses++;
      checks++;
      if (frame_done !== (i == 7)) begin
        errors++;
        $display("FAIL mid_frame_done[%0d] got %b want %b", i, frame_done, (i == 7));
      end
    end
    shift_ctrl = 1'b0;
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL mid_pulse_count got %0d want 1", pulses);
    end
  endtask

`ifdef ROTATE_EN
  task automatic test_rotate();
    load = 1'b1;
    p_in = 8'h81;
    tick();
    load       = 1'b0;
    rotate     = 1'b1;
    s_in       = 1'b0;
    dir        = 1'b0;
    shift_ctrl = 1'b1;
    tick();
    checks++;
    if (p_out !== 8'h03) begin
      errors++;
      $display("FAIL rot_up got %h want 03", p_out);
    end
    dir = 1'b1;
    tick();
    tick();
    checks++;
    if (p_out !== 8'hC0) begin
      errors++;
      $display("FAIL rot_down got %h want c0", p_out);
    end
    shift_ctrl = 1'b0;
    load       = 1'b1;
    p_in       = 8'h81;
    tick();
    load       = 1'b0;
    dir        = 1'b0;
    shift_ctrl = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    shift_ctrl = 1'b0;
    checks++;
    if (p_out !== 8'h81 || frame_done !== 1'b1) begin
      errors++;
      $display("FAIL rot_full got p_out=%h fd=%b want 81 1", p_out, frame_done);
    end
    rotate = 1'b0;
  endtask
`endif

  initial begin
    checks     = 0;
    errors     = 0;
    clear      = 1'b1;
    shift_ctrl = 1'b0;
    dir        = 1'b0;
    s_in       = 1'b0;
    load       = 1'b0;
    p_in       = 8'h00;
`ifdef ROTATE_EN
    rotate     = 1'b0;
`endif
    tick();
    test_reset();
    test_fill();
    test_drain();
    test_priority_hold();
    test_mid_frame_clear();
`ifdef ROTATE_EN
    test_rotate();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
